wb_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one Wishbone device port between N Wishbone controllers (e.g. several debug-button controllers driving one LED/register device).
- Sits between the controller-side and device-side Wishbone interfaces.
- Grants whole cycles (cyc-based ownership) and forwards the pipelined stb/stall handshake to and from the current owner.
- Has a watchdog: it aborts a cycle with an error response if the device never responds.

---
 rtl/wb_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N controllers share one device port with
// whole-cycle ownership and a watchdog that aborts cycles the device ignores.
module wb_rr_arbiter #(
  parameter int N         = 4,
  parameter int DAT_WIDTH = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N-1:0]           cyc_i,
  input  logic [N-1:0]           stb_i,
  input  logic [N-1:0]           we_i,
  input  logic [N*DAT_WIDTH-1:0] dat_i,
  output logic [N-1:0]           ack_o,
  output logic [N-1:0]           err_o,
  output logic [N-1:0]           rty_o,
  output logic [N-1:0]           stall_o,
  output logic                   cyc_o,
  output logic                   stb_o,
  output logic                   we_o,
  output logic [DAT_WIDTH-1:0]   dat_o,
  input  logic                   ack_i,
  input  logic                   err_i,
  input  logic                   rty_i,
  input  logic                   stall_i,
  output logic [N-1:0]           grant_o
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, OWNED, ABORT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic                 own_cyc, own_stb, own_we;
  logic [DAT_WIDTH-1:0] own_dat;
  logic                 dev_rsp, accepted, timeout_hit;
  logic                 arb_found;
  logic [IDX_W-1:0]     arb_idx;

  assign own_cyc = cyc_i[owner_q];
  assign own_stb = stb_i[owner_q];
  assign own_we  = we_i[owner_q];
  assign own_dat = dat_i[owner_q*DAT_WIDTH +: DAT_WIDTH];

  assign dev_rsp  = ack_i | err_i | rty_i;
  assign accepted = own_stb & ~stall_i;
  // A real device response in the limit cycle beats the synthesized error.
  assign timeout_hit = (state_q == OWNED) && (wd_q == WD_LIMIT) && !dev_rsp;

  // Search starts just after the last winner, so the previous owner is checked last.
  always_comb begin
    int j;
    arb_found = 1'b0;
    arb_idx   = '0;
    j         = 0;
    for (int i = 1; i <= N; i++) begin
      j = int'(last_q) + i;
      if (j >= N) j = j - N;
      if (!arb_found && cyc_i[IDX_W'(j)]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = OWNED;
          owner_d = arb_idx;
          last_d  = arb_idx;
          wd_d    = '0;
        end
      end
      OWNED: begin
        if (!own_cyc)                 state_d = IDLE;
        else if (timeout_hit)         state_d = ABORT;
        else if (dev_rsp || accepted) wd_d    = '0;
        else                          wd_d    = wd_q + WD_W'(1);
      end
      ABORT: begin
        if (!own_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Non-owners always see stall mirror their own strobe so their requests wait intact.
  always_comb begin
    grant_o = '0;
    cyc_o   = 1'b0;
    stb_o   = 1'b0;
    we_o    = 1'b0;
    dat_o   = '0;
    ack_o   = '0;
    err_o   = '0;
    rty_o   = '0;
    stall_o = stb_i;
    unique case (state_q)
      OWNED: begin
        grant_o[owner_q] = 1'b1;
        cyc_o            = own_cyc;
        stb_o            = own_stb;
        we_o             = own_we;
        dat_o            = own_dat;
        ack_o[owner_q]   = ack_i;
        err_o[owner_q]   = err_i | timeout_hit;
        rty_o[owner_q]   = rty_i;
        stall_o[owner_q] = stall_i;
      end
      ABORT: begin
        grant_o[owner_q] = 1'b1;
        stall_o[owner_q] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: vector table, directed multi-cycle sequences and a
// randomized run against a behavioural round-robin model.
module tb_wb_rr_arbiter;

  localparam int N = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  cyc_i, stb_i, we_i;
  logic [N*DW-1:0] dat_i;
  logic [N-1:0]  ack_o, err_o, rty_o, stall_o, grant_o;
  logic          cyc_o, stb_o, we_o;
  logic [DW-1:0] dat_o;
  logic          ack_i, err_i, rty_i, stall_i;

  int n_checks = 0;
  int n_fail   = 0;

  wb_rr_arbiter #(.N(N), .DAT_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .dat_i(dat_i),
    .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o), .stall_o(stall_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .dat_o(dat_o),
    .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i), .stall_i(stall_i),
    .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          rst;
    logic [3:0]  cyc, stb, we;
    logic [31:0] dat;
    logic [3:0]  dev;   // {ack, err, rty, stall}
    logic [3:0]  egrant;
    logic [2:0]  ecsw;  // {cyc_o, stb_o, we_o}
    logic [7:0]  edat;
    logic [3:0]  eack, eerr, erty, estall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit rst, input logic [3:0] cyc, input logic [3:0] stb,
                              input logic [3:0] we, input logic [31:0] dat, input logic [3:0] dev,
                              input logic [3:0] g, input logic [2:0] csw, input logic [7:0] d,
                              input logic [3:0] a, input logic [3:0] e, input logic [3:0] r,
                              input logic [3:0] st);
    vec_t v;
    v.rst = rst; v.cyc = cyc; v.stb = stb; v.we = we; v.dat = dat; v.dev = dev;
    v.egrant = g; v.ecsw = csw; v.edat = d; v.eack = a; v.eerr = e; v.erty = r; v.estall = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] cyc, input logic [3:0] stb, input logic [3:0] we,
                       input logic [31:0] dat, input logic [3:0] dev);
    cyc_i = cyc; stb_i = stb; we_i = we; dat_i = dat;
    {ack_i, err_i, rty_i, stall_i} = dev;
  endtask

  task automatic pulse_reset();
    step();
    rst_ni = 1'b0;
    drive(4'b0, 4'b0, 4'b0, 32'h0, 4'b0);
    step();
    step();
    rst_ni = 1'b1;
  endtask

  // Behavioural model state
  int         m_owner;   // -1 when nobody owns the device port
  int         m_last;
  int         m_quiet;   // counting cycles since the last device activity
  bit         m_abort;

  task automatic model_check(input int cyc_n);
    logic [3:0]  e_grant, e_ack, e_err, e_rty, e_stall;
    logic [10:0] e_fwd;
    logic        resp;
    resp    = ack_i | err_i | rty_i;
    e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0; e_stall = stb_i; e_fwd = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      if (!m_abort) begin
        e_fwd = {cyc_i[m_owner], stb_i[m_owner], we_i[m_owner], dat_i[m_owner*DW +: DW]};
        e_ack[m_owner]   = ack_i;
        e_rty[m_owner]   = rty_i;
        e_err[m_owner]   = err_i | (m_quiet == TO && !resp);
        e_stall[m_owner] = stall_i;
      end else begin
        e_stall[m_owner] = 1'b1;
      end
    end
    check($sformatf("rand[%0d].grant", cyc_n), 64'(grant_o), 64'(e_grant));
    check($sformatf("rand[%0d].fwd", cyc_n), 64'({cyc_o, stb_o, we_o, dat_o}), 64'(e_fwd));
    check($sformatf("rand[%0d].rsp", cyc_n), 64'({ack_o, err_o, rty_o, stall_o}),
          64'({e_ack, e_err, e_rty, e_stall}));
  endtask

  task automatic model_update();
    logic resp;
    resp = ack_i | err_i | rty_i;
    if (m_owner < 0) begin
      for (int d = 1; d <= N; d++) begin
        if (m_owner < 0 && cyc_i[(m_last + d) % N]) m_owner = (m_last + d) % N;
      end
      if (m_owner >= 0) begin
        m_last = m_owner; m_quiet = 0; m_abort = 1'b0;
      end
    end else if (!cyc_i[m_owner]) begin
      m_owner = -1;
    end else if (!m_abort) begin
      if (m_quiet == TO && !resp)                          m_abort = 1'b1;
      else if (resp || (stb_i[m_owner] && !stall_i))       m_quiet = 0;
      else                                                 m_quiet++;
    end
  endtask

  initial begin
    logic [31:0] dr, ds, d1;
    logic [3:0]  r_cyc, b, dev;
    int          early;
    bit          dead;

    dr = 32'h4433_2211;
    ds = 32'h0000_5A3C;
    d1 = 32'h00A5_0000;

    // Single one-beat write from requester 2
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100, d1, 4'b0000, 4'b0000, 3'b000, 8'h00, 4'b0, 4'b0, 4'b0, 4'b0100));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100, d1, 4'b0000, 4'b0100, 3'b111, 8'hA5, 4'b0, 4'b0, 4'b0, 4'b0000));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, d1, 4'b1000, 4'b0100, 3'b101, 8'hA5, 4'b0100, 4'b0, 4'b0, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0100, 3'b000, 8'h00, 4'b0, 4'b0, 4'b0, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0000, 3'b000, 8'h00, 4'b0, 4'b0, 4'b0, 4'b0000));
    // Reset with every requester asking: nothing granted, stall mirrors strobe
    vecs.push_back(mk(1, 4'b1111, 4'b0101, 4'b1111, dr, 4'b1000, 4'b0000, 3'b000, 8'h00, 4'b0, 4'b0, 4'b0, 4'b0101));
    // Round robin with all four requesting: order 0,1,2,3,0
    for (int g = 0; g < 5; g++) begin
      int k;
      logic [3:0] oh;
      k  = g % N;
      oh = 4'(1 << k);
      dev = (k == 1) ? 4'b0100 : (k == 2) ? 4'b0010 : 4'b1000;
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, dr, 4'b0000, 4'b0000, 3'b000, 8'h00,
                        4'b0, 4'b0, 4'b0, 4'b0000));
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, dr, dev, oh, 3'b110, 8'(8'h11 * (k + 1)),
                        (dev[3] ? oh : 4'b0), (dev[2] ? oh : 4'b0), (dev[1] ? oh : 4'b0), 4'b1111 & ~oh));
      vecs.push_back(mk(0, 4'b1111 & ~oh, 4'b0000, 4'b0000, dr, 4'b0000, oh, 3'b000, 8'(8'h11 * (k + 1)),
                        4'b0, 4'b0, 4'b0, 4'b0000));
    end
    // Stall pass-through: owner 1 stalled 3 cycles while requester 0 waits
    vecs.push_back(mk(0, 4'b0011, 4'b0011, 4'b0010, ds, 4'b0000, 4'b0000, 3'b000, 8'h00, 4'b0, 4'b0, 4'b0, 4'b0011));
    vecs.push_back(mk(0, 4'b0011, 4'b0011, 4'b0010, ds, 4'b0001, 4'b0010, 3'b111, 8'h5A, 4'b0, 4'b0, 4'b0, 4'b0011));
    vecs.push_back(mk(0, 4'b0011, 4'b0010, 4'b0010, ds, 4'b0001, 4'b0010, 3'b111, 8'h5A, 4'b0, 4'b0, 4'b0, 4'b0010));
    vecs.push_back(mk(0, 4'b0011, 4'b0011, 4'b0010, ds, 4'b0001, 4'b0010, 3'b111, 8'h5A, 4'b0, 4'b0, 4'b0, 4'b0011));
    vecs.push_back(mk(0, 4'b0011, 4'b0011, 4'b0010, ds, 4'b0000, 4'b0010, 3'b111, 8'h5A, 4'b0, 4'b0, 4'b0, 4'b0001));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, 4'b0010, ds, 4'b1000, 4'b0010, 3'b101, 8'h5A, 4'b0010, 4'b0, 4'b0, 4'b0001));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, ds, 4'b0000, 4'b0010, 3'b000, 8'h5A, 4'b0, 4'b0, 4'b0, 4'b0001));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, ds, 4'b0000, 4'b0000, 3'b000, 8'h00, 4'b0, 4'b0, 4'b0, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, ds, 4'b0000, 4'b0001, 3'b000, 8'h3C, 4'b0, 4'b0, 4'b0, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0000, 3'b000, 8'h00, 4'b0, 4'b0, 4'b0, 4'b0000));

    // Reset state
    rst_ni = 1'b0;
    drive(4'b0000, 4'b1010, 4'b1111, 32'hFFFF_FFFF, 4'b1000);
    #3;
    check("reset.grant", 64'(grant_o), 64'(4'b0));
    check("reset.fwd", 64'({cyc_o, stb_o, we_o, dat_o}), 64'(11'b0));
    check("reset.rsp", 64'({ack_o, err_o, rty_o}), 64'(12'b0));
    check("reset.stall", 64'(stall_o), 64'(4'b1010));
    step();
    step();
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      step();
      rst_ni = !vecs[i].rst;
      drive(vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].dat, vecs[i].dev);
      #2;
      check($sformatf("vec[%0d].grant", i), 64'(grant_o), 64'(vecs[i].egrant));
      check($sformatf("vec[%0d].cyc_stb_we", i), 64'({cyc_o, stb_o, we_o}), 64'(vecs[i].ecsw));
      check($sformatf("vec[%0d].dat", i), 64'(dat_o), 64'(vecs[i].edat));
      check($sformatf("vec[%0d].ack", i), 64'(ack_o), 64'(vecs[i].eack));
      check($sformatf("vec[%0d].err", i), 64'(err_o), 64'(vecs[i].eerr));
      check($sformatf("vec[%0d].rty", i), 64'(rty_o), 64'(vecs[i].erty));
      check($sformatf("vec[%0d].stall", i), 64'(stall_o), 64'(vecs[i].estall));
    end

    // Watchdog timeout on owner 0, requester 1 waiting
    pulse_reset();
    step(); drive(4'b0011, 4'b0000, 4'b0000, 32'h77, 4'b0000); #2;
    check("to.idle_grant", 64'(grant_o), 64'(4'b0000));
    step(); drive(4'b0011, 4'b0001, 4'b0001, 32'h77, 4'b0000); #2;
    check("to.grant", 64'(grant_o), 64'(4'b0001));
    check("to.accept_err", 64'(err_o), 64'(4'b0000));
    early = 0;
    for (int i = 0; i < TO; i++) begin
      step();
      if (i % 2 == 0) drive(4'b0011, 4'b0001, 4'b0001, 32'h77, 4'b0001);
      else            drive(4'b0011, 4'b0000, 4'b0001, 32'h77, 4'b0000);
      #2;
      if (err_o != 4'b0000) early++;
    end
    check("to.no_early_err", 64'(early), 64'(0));
    step(); drive(4'b0011, 4'b0000, 4'b0000, 32'h77, 4'b0000); #2;
    check("to.err_pulse", 64'(err_o), 64'(4'b0001));
    check("to.cyc_at_limit", 64'(cyc_o), 64'(1'b1));
    step(); drive(4'b0011, 4'b0000, 4'b0000, 32'h77, 4'b1000); #2;
    check("to.abort_cyc_stb", 64'({cyc_o, stb_o}), 64'(2'b00));
    check("to.late_ack", 64'(ack_o), 64'(4'b0000));
    check("to.abort_err", 64'(err_o), 64'(4'b0000));
    check("to.abort_grant", 64'(grant_o), 64'(4'b0001));
    check("to.abort_stall", 64'(stall_o), 64'(4'b0001));
    step(); drive(4'b0010, 4'b0000, 4'b0000, 32'h77, 4'b0000); #2;
    check("to.abort_hold", 64'(grant_o), 64'(4'b0001));
    step(); #2;
    check("to.idle_gap", 64'(grant_o), 64'(4'b0000));
    step(); #2;
    check("to.next_owner", 64'(grant_o), 64'(4'b0010));
    step(); drive(4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0000);
    step();

    // Device response in the same cycle the watchdog hits its limit
    step(); drive(4'b0100, 4'b0000, 4'b0000, 32'h0, 4'b0000); #2;
    step(); drive(4'b0100, 4'b0100, 4'b0000, 32'h0, 4'b0000); #2;
    check("lim.grant", 64'(grant_o), 64'(4'b0100));
    early = 0;
    for (int i = 0; i < TO; i++) begin
      step(); drive(4'b0100, 4'b0000, 4'b0000, 32'h0, 4'b0000); #2;
      if (err_o != 4'b0000) early++;
    end
    check("lim.no_early_err", 64'(early), 64'(0));
    step(); drive(4'b0100, 4'b0000, 4'b0000, 32'h0, 4'b1000); #2;
    check("lim.ack", 64'(ack_o), 64'(4'b0100));
    check("lim.err", 64'(err_o), 64'(4'b0000));
    step(); drive(4'b0100, 4'b0000, 4'b0000, 32'h0, 4'b0000); #2;
    check("lim.still_owned", 64'({grant_o, cyc_o}), 64'({4'b0100, 1'b1}));
    check("lim.no_err_after", 64'(err_o), 64'(4'b0000));
    step(); drive(4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0000);
    step();

    // Asynchronous reset in the middle of an owned cycle
    step(); drive(4'b1000, 4'b0000, 4'b0000, 32'h0, 4'b0000); #2;
    step(); drive(4'b1000, 4'b1000, 4'b0000, 32'h0, 4'b0000); #2;
    check("ar.owned", 64'({grant_o, cyc_o}), 64'({4'b1000, 1'b1}));
    #2 rst_ni = 1'b0;
    #1;
    check("ar.async_drop", 64'({grant_o, cyc_o, stb_o}), 64'(7'b0));
    check("ar.async_stall", 64'(stall_o), 64'(4'b1000));
    step(); drive(4'b1111, 4'b0000, 4'b0000, 32'h0, 4'b0000); #2;
    check("ar.held", 64'(grant_o), 64'(4'b0000));
    step(); rst_ni = 1'b1; #2;
    check("ar.released_idle", 64'(grant_o), 64'(4'b0000));
    step(); #2;
    check("ar.first_winner", 64'(grant_o), 64'(4'b0001));
    step(); drive(4'b0000, 4'b0000, 4'b0000, 32'h0, 4'b0000);
    step();

    // Randomized traffic against the behavioural model
    pulse_reset();
    m_owner = -1; m_last = N - 1; m_quiet = 0; m_abort = 1'b0;
    r_cyc = '0;
    dead  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int k = 0; k < N; k++)
        if ($urandom_range(15) == 0) r_cyc[k] = ~r_cyc[k];
      if ($urandom_range(31) == 0) dead = !dead;
      b = 4'($urandom);
      if (dead) dev = 4'b0001;
      else dev = {($urandom_range(7) == 0), ($urandom_range(15) == 0),
                  ($urandom_range(15) == 0), 1'($urandom_range(1))};
      drive(r_cyc, b, 4'($urandom), $urandom, dev);
      #2;
      model_check(c);
      model_update();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
